// File: rtl/mem_req_bridge.sv
// mem_req_bridge
// In-order bridge between RTL masters and the external memory model.
// Store/retrieve requests are buffered in a request FIFO and issued one per
// memory handshake, strictly in arrival order. Retrieve data comes back on
// mem_rvalid, is buffered, and is returned to the master over a valid/ready
// response channel. The outstanding count covers retrieves that are in
// flight or buffered, so capping it at MAX_OUT also bounds the response
// buffer and mem_rvalid never needs backpressure.
module mem_req_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 16,
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_write,
   input  logic [ADDR_W-1:0]          req_addr,
   input  logic [DATA_W-1:0]          req_wdata,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [DATA_W-1:0]          rsp_rdata,
   output logic                       mem_valid,
   input  logic                       mem_ready,
   output logic                       mem_write,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic                       mem_rvalid,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int RW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Request FIFO
   req_t              fifo_mem [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   // Response buffer and outstanding-retrieve tracking
   logic [DATA_W-1:0] rb_mem [MAX_OUT];
   logic [RW-1:0]     rb_wr_q, rb_wr_d;
   logic [RW-1:0]     rb_rd_q, rb_rd_d;
   logic [OW-1:0]     rb_cnt_q, rb_cnt_d;
   logic [OW-1:0]     out_q, out_d;
   logic              err_q, err_d;

   logic              push, pop, issue_rd, rsp_pop, rb_push, stray;
   logic              fifo_empty;
   req_t              head;

   // Response-buffer pointer increment with explicit wrap at MAX_OUT.
   function automatic logic [RW-1:0] rb_inc(input logic [RW-1:0] p);
      return (p == RW'(MAX_OUT - 1)) ? '0 : p + RW'(1);
   endfunction

   assign fifo_empty = (count_q == '0);
   assign head       = fifo_mem[rd_ptr_q];

   // A full FIFO stays not-ready even when a pop happens in the same cycle.
   assign req_ready  = (count_q < CW'(DEPTH));
   assign push       = req_valid && req_ready;

   // Stores always issue; a retrieve at the head waits for an outstanding slot.
   assign mem_valid  = !fifo_empty && (head.write || (out_q < OW'(MAX_OUT)));
   assign pop        = mem_valid && mem_ready;
   assign issue_rd   = pop && !head.write;

   assign rsp_valid  = (rb_cnt_q != '0);
   assign rsp_pop    = rsp_valid && rsp_ready;
   assign rb_push    = mem_rvalid && (out_q != '0);
   assign stray      = mem_rvalid && (out_q == '0);

   assign count      = count_q;
   assign err        = err_q;

   // Output fields: head entry / buffer head, forced to zero while empty.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      rsp_rdata = '0;
      if (!fifo_empty) begin
         mem_write = head.write;
         mem_addr  = head.addr;
         mem_wdata = head.wdata;
      end
      if (rsp_valid) begin
         rsp_rdata = rb_mem[rb_rd_q];
      end
   end

   // Next-state for pointers, occupancies, outstanding count and sticky error.
   always_comb begin
      wr_ptr_d = push    ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;
      rb_wr_d  = rb_push ? rb_inc(rb_wr_q)   : rb_wr_q;
      rb_rd_d  = rsp_pop ? rb_inc(rb_rd_q)   : rb_rd_q;
      err_d    = err_q || stray;

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      unique case ({issue_rd, rsp_pop})
         2'b10:   out_d = out_q + OW'(1);
         2'b01:   out_d = out_q - OW'(1);
         default: out_d = out_q;
      endcase

      unique case ({rb_push, rsp_pop})
         2'b10:   rb_cnt_d = rb_cnt_q + OW'(1);
         2'b01:   rb_cnt_d = rb_cnt_q - OW'(1);
         default: rb_cnt_d = rb_cnt_q;
      endcase
   end

   // Control state register; reset discards all queued and in-flight work.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rb_wr_q  <= '0;
         rb_rd_q  <= '0;
         rb_cnt_q <= '0;
         out_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         rb_wr_q  <= rb_wr_d;
         rb_rd_q  <= rb_rd_d;
         rb_cnt_q <= rb_cnt_d;
         out_q    <= out_d;
         err_q    <= err_d;
      end
   end

   // Storage writes for request FIFO and response buffer.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays are not reset; occupancy counters gate every read.
      if (push) begin
         fifo_mem[wr_ptr_q] <= '{write: req_write, addr: req_addr, wdata: req_wdata};
      end
      if (rb_push) begin
         rb_mem[rb_wr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_req_bridge.sv
// Testbench for mem_req_bridge: directed scenarios plus a randomized burst,
// checked against a sequential-memory reference model and an in-order
// memory stub with 2-cycle read latency.
module tb_mem_req_bridge;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 4;
   localparam int LAT     = 2;

   logic        clk, rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_rdata;
   logic        mem_valid, mem_ready, mem_write;
   logic [31:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic [2:0]  count;
   logic        err;

   mem_req_bridge #(.ADDR_W(32), .DATA_W(16), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .count(count), .err(err)
   );

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [15:0] d;
   } tb_req_t;

   typedef struct {
      logic [15:0] d;
      int          due;
   } pend_t;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // Reference model state (sequential memory semantics, in-order bridge)
   tb_req_t     acc_q[$];
   logic [15:0] exp_rsp[$];
   logic [15:0] ref_mem[logic [31:0]];
   int          n_out   = 0;
   int          n_buf   = 0;
   logic        exp_err = 1'b0;
   logic [15:0] rsp_log[$];
   logic        iss_log[$];
   int          n_iss_rd = 0;

   // Memory stub state
   logic [15:0] stub_mem[logic [31:0]];
   pend_t       pend[$];
   int          inject_req  = 0;
   int          inject_done = 0;

   // Ready-line modes: 0 = low, 1 = high, 2 = random
   int mem_mode = 1;
   int rsp_mode = 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Unwritten memory locations read back as address*3.
   function automatic logic [15:0] def_val(input logic [31:0] a);
      return 16'(a * 3);
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Ready-line driver
   initial begin
      mem_ready = 1'b0;
      rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         mem_ready = (mem_mode == 2) ? 1'($urandom % 2) : (mem_mode == 1);
         rsp_ready = (rsp_mode == 2) ? 1'($urandom % 2) : (rsp_mode == 1);
      end
   end

   // In-order memory stub: reads sampled at issue, returned LAT cycles later
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pend.delete();
         end else if (mem_valid && mem_ready) begin
            if (mem_write) stub_mem[mem_addr] = mem_wdata;
            else pend.push_back('{d: (stub_mem.exists(mem_addr) ? stub_mem[mem_addr] : def_val(mem_addr)),
                                  due: cyc + LAT});
         end
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend[0].d;
            void'(pend.pop_front());
         end else if (inject_req != inject_done) begin
            mem_rvalid  = 1'b1;
            mem_rdata   = 16'hDEAD;
            inject_done = inject_req;
         end
      end
   end

   // Scoreboard: compares state every cycle, then applies the upcoming edge
   initial begin
      int          out_now;
      tb_req_t     hd;
      logic [15:0] v;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc_q.delete();
            exp_rsp.delete();
            n_out   = 0;
            n_buf   = 0;
            exp_err = 1'b0;
         end else begin
            out_now = n_out;
            check("count", 32'(count), 32'(acc_q.size()));
            check("req_ready", 32'(req_ready), 32'(acc_q.size() < DEPTH));
            check("mem_valid", 32'(mem_valid),
                  32'(acc_q.size() > 0 && (acc_q[0].w || out_now < MAX_OUT)));
            check("rsp_valid", 32'(rsp_valid), 32'(n_buf > 0));
            check("err", 32'(err), 32'(exp_err));
            if (mem_valid && mem_ready && acc_q.size() > 0) begin
               hd = acc_q.pop_front();
               check("iss_write", 32'(mem_write), 32'(hd.w));
               check("iss_addr", mem_addr, hd.a);
               if (hd.w) check("iss_wdata", 32'(mem_wdata), 32'(hd.d));
               iss_log.push_back(hd.w);
               if (!hd.w) begin
                  n_out++;
                  n_iss_rd++;
               end
            end
            if (mem_rvalid) begin
               if (out_now == 0) exp_err = 1'b1;
               else n_buf++;
            end
            if (rsp_valid && rsp_ready) begin
               if (exp_rsp.size() == 0) begin
                  check("rsp_extra", 32'(rsp_rdata), 32'hFFFF_FFFF);
               end else begin
                  v = exp_rsp.pop_front();
                  check("rsp_data", 32'(rsp_rdata), 32'(v));
               end
               rsp_log.push_back(rsp_rdata);
               n_buf--;
               n_out--;
            end
            if (req_valid && req_ready) begin
               acc_q.push_back('{w: req_write, a: req_addr, d: req_wdata});
               if (req_write) ref_mem[req_addr] = req_wdata;
               else exp_rsp.push_back(ref_mem.exists(req_addr) ? ref_mem[req_addr] : def_val(req_addr));
            end
         end
      end
   end

   // Present one request and hold it until accepted (bounded).
   task automatic put(input logic w, input logic [31:0] a, input logic [15:0] d);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("put_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait until no request is queued and no retrieve is pending (bounded).
   task automatic drain();
      bit ok = 1'b0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         #1;
         if (acc_q.size() == 0 && n_out == 0 && n_buf == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("drain_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_rsp, base_iss, base_rd;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      #1 rst = 1'b1;
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mem_valid", 32'(mem_valid), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_mem_fields", {15'd0, mem_write, mem_wdata} | mem_addr, 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;

      // 1: store then retrieve the same address
      mem_mode = 1; rsp_mode = 1;
      base_rsp = rsp_log.size();
      base_iss = iss_log.size();
      put(1'b1, 32'd100, 16'd1024);
      put(1'b0, 32'd100, 16'd0);
      drain();
      wait_cycles(3);
      check("t1_rsp_cnt", 32'(rsp_log.size() - base_rsp), 32'd1);
      if (rsp_log.size() > base_rsp) check("t1_rsp_val", 32'(rsp_log[base_rsp]), 32'd1024);
      check("t1_iss_cnt", 32'(iss_log.size() - base_iss), 32'd2);
      if (iss_log.size() >= base_iss + 2) begin
         check("t1_wr_seq0", 32'(iss_log[base_iss]), 32'd1);
         check("t1_wr_seq1", 32'(iss_log[base_iss + 1]), 32'd0);
      end
      check("t1_err", 32'(err), 32'd0);

      // 2: fill the FIFO with memory stalled, then release
      mem_mode = 0;
      wait_cycles(2);
      for (int i = 0; i < 4; i++) put(1'b1, 32'(10 + i), 16'(16'h0100 + i));
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'd14; req_wdata = 16'h0104;
      repeat (3) @(negedge clk);
      check("t2_count_full", 32'(count), 32'd4);
      check("t2_not_ready", 32'(req_ready), 32'd0);
      mem_mode = 1;
      begin
         bit seen = 1'b0;
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_valid && mem_ready) begin
               seen = 1'b1;
               break;
            end
         end
         check("t2_pop_seen", 32'(seen), 32'd1);
         check("t2_no_bypass", 32'(req_ready), 32'd0);
         @(negedge clk);
         check("t2_ready_after_pop", 32'(req_ready), 32'd1);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      drain();

      // 3: outstanding cap with response channel stalled
      rsp_mode = 0;
      base_rsp = rsp_log.size();
      base_rd  = n_iss_rd;
      for (int i = 0; i < 6; i++) put(1'b0, 32'(i), 16'd0);
      wait_cycles(10);
      check("t3_issued", 32'(n_iss_rd - base_rd), 32'd4);
      check("t3_stall", 32'(mem_valid), 32'd0);
      check("t3_queued", 32'(count), 32'd2);
      rsp_mode = 1;
      drain();
      wait_cycles(2);
      check("t3_rsp_cnt", 32'(rsp_log.size() - base_rsp), 32'd6);
      if (rsp_log.size() >= base_rsp + 6) begin
         check("t3_first", 32'(rsp_log[base_rsp]), 32'd0);
         check("t3_last", 32'(rsp_log[base_rsp + 5]), 32'd15);
      end

      // 4: interleaved store/retrieve to one address with random ready lines
      mem_mode = 2; rsp_mode = 2;
      base_rsp = rsp_log.size();
      put(1'b1, 32'd7, 16'h00AA);
      put(1'b0, 32'd7, 16'd0);
      put(1'b1, 32'd7, 16'h0055);
      put(1'b0, 32'd7, 16'd0);
      drain();
      check("t4_rsp_cnt", 32'(rsp_log.size() - base_rsp), 32'd2);
      if (rsp_log.size() >= base_rsp + 2) begin
         check("t4_rsp0", 32'(rsp_log[base_rsp]), 32'h00AA);
         check("t4_rsp1", 32'(rsp_log[base_rsp + 1]), 32'h0055);
      end

      // Randomized burst over a small address window
      for (int i = 0; i < 40; i++) begin
         put(1'($urandom % 2), 32'($urandom % 8), 16'($urandom));
         if ($urandom % 4 == 0) wait_cycles(1 + $urandom % 3);
      end
      drain();
      mem_mode = 1; rsp_mode = 1;
      wait_cycles(2);

      // 5: stray mem_rvalid sets a sticky error
      inject_req++;
      wait_cycles(3);
      check("t5_err_set", 32'(err), 32'd1);
      check("t5_no_rsp", 32'(rsp_valid), 32'd0);
      wait_cycles(5);
      check("t5_err_sticky", 32'(err), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t5_err_cleared", 32'(err), 32'd0);
      @(posedge clk);
      #2 rst = 1'b0;

      // 6: asynchronous reset with work queued and in flight
      rsp_mode = 0; mem_mode = 1;
      wait_cycles(2);
      put(1'b0, 32'd300, 16'd0);
      put(1'b0, 32'd301, 16'd0);
      wait_cycles(6);
      mem_mode = 0;
      wait_cycles(2);
      for (int i = 0; i < 3; i++) put(1'b0, 32'(302 + i), 16'd0);
      wait_cycles(2);
      check("t6_pre_count", 32'(count), 32'd3);
      check("t6_pre_rsp", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("t6_count", 32'(count), 32'd0);
      check("t6_mem_valid", 32'(mem_valid), 32'd0);
      check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
      check("t6_req_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      mem_mode = 1; rsp_mode = 1;
      base_rsp = rsp_log.size();
      put(1'b1, 32'd200, 16'h7FFF);
      put(1'b0, 32'd200, 16'd0);
      drain();
      wait_cycles(3);
      check("t6_rsp_cnt", 32'(rsp_log.size() - base_rsp), 32'd1);
      if (rsp_log.size() > base_rsp) check("t6_rsp_val", 32'(rsp_log[base_rsp]), 32'h7FFF);
      check("t6_err", 32'(err), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
